// File: rtl/fifo_unpack_reader_pkg.sv
// Shared definitions for the triple-word FIFO reader: lane geometry, FSM
// encoding and the entry-width helper that the FIFO side uses as well.
package fifo_unpack_reader_pkg;

  localparam int LANES  = 3;
  localparam int LANE_W = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // One FIFO entry carries LANES channel words.
  function automatic int entry_w(input int data_width);
    return LANES * data_width;
  endfunction

endpackage

// File: rtl/fifo_unpack_reader.sv
// Reads triple-word entries from the channel FIFO and replays them as a
// one-word-per-beat valid/ready stream with lane and frame markers.
module fifo_unpack_reader
  import fifo_unpack_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 25
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           clr,
  input  logic                           fifo_empty,
  input  logic [entry_w(DATA_WIDTH)-1:0] fifo_data,
  output logic                           fifo_rd_req,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic [LANE_W-1:0]              m_lane,
  output logic                           m_frame_last
);

  localparam int                CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(FRAME_LEN - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

  state_t                           state, state_d;
  logic [LANE_W-1:0]                lane, lane_d;
  logic [CNT_W-1:0]                 cnt, cnt_d;
  logic [LANES-1:0][DATA_WIDTH-1:0] ent_q;
  logic                             hold, hs, last_hs;

  assign hold    = (state == ST_HOLD);
  assign hs      = hold & m_ready;
  assign last_hs = hs & (lane == LANE_LAST);

  // Reload while the last lane drains keeps the stream bubble-free; the
  // FIFO has no underflow guard, so empty must block the request here.
  assign fifo_rd_req = ~rst & en & ~fifo_empty & ~clr & (~hold | last_hs);

  always_comb begin
    state_d = state;
    lane_d  = lane;
    cnt_d   = cnt;
    if (clr) begin
      state_d = ST_EMPTY;
      lane_d  = '0;
      cnt_d   = '0;
    end else begin
      if (hs) lane_d = lane + 1'b1;
      if (last_hs) begin
        cnt_d   = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        state_d = ST_EMPTY;
        lane_d  = '0;
      end
      if (fifo_rd_req) begin
        state_d = ST_HOLD;
        lane_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
      lane  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      lane  <= lane_d;
      cnt   <= cnt_d;
    end
  end

  // FIFO data is only valid during the request cycle, so capture it then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              ent_q <= '0;
    else if (fifo_rd_req) ent_q <= fifo_data;
  end

  always_comb begin
    m_data = '0;
    if (hold) begin
      case (lane)
        2'd0:    m_data = ent_q[0];
        2'd1:    m_data = ent_q[1];
        2'd2:    m_data = ent_q[2];
        default: m_data = '0;
      endcase
    end
  end

  assign m_valid      = hold;
  assign m_lane       = hold ? lane : '0;
  assign m_frame_last = hold & (lane == LANE_LAST) & (cnt == CNT_MAX);

endmodule

// File: tb/tb_fifo_unpack_reader.sv
// Bench for fifo_unpack_reader: behavioural FIFO, entry-level scoreboard and
// a monitor that checks every accepted word plus the read/stall rules.
module tb_fifo_unpack_reader;
  import fifo_unpack_reader_pkg::*;

  localparam int DW = 32;
  localparam int FL = 2;
  localparam int EW = 3 * DW;

  logic          clk = 1'b0;
  logic          rst, en, clr, m_ready;
  logic          fifo_empty, fifo_rd_req, m_valid, m_frame_last;
  logic [EW-1:0] fifo_data;
  logic [DW-1:0] m_data;
  logic [1:0]    m_lane;

  always #5 clk = ~clk;

  fifo_unpack_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_req(fifo_rd_req),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_lane(m_lane),
    .m_frame_last(m_frame_last)
  );

  // Show-ahead FIFO stand-in: data driven only while a read is requested.
  logic [EW-1:0] mem [0:63];
  logic [6:0]    wp = '0, rp = '0;
  assign fifo_empty = (wp == rp);
  assign fifo_data  = fifo_rd_req ? mem[rp[5:0]] : '0;
  always @(posedge clk) if (fifo_rd_req) rp <= rp + 7'd1;

  typedef struct { logic [DW-1:0] d; logic [1:0] l; } exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0;
  int ent_done = 0, word_idx = 0, rd_cnt = 0, run = 0, max_run = 0;
  logic [31:0]   last_mask = '0;
  logic          stall_prev = 1'b0, hs_prev = 1'b0;
  logic [DW-1:0] prev_d;
  logic [1:0]    prev_l;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic push(input logic [EW-1:0] e);
    exp_t x;
    mem[wp[5:0]] = e;
    wp = wp + 7'd1;
    for (int i = 0; i < 3; i++) begin
      x.d = e[i*DW +: DW];
      x.l = 2'(i);
      exp_q.push_back(x);
    end
  endtask

  task automatic push_rand();
    push({$urandom, $urandom, $urandom});
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!m_valid && k < 20) begin step(); k++; end
    chk(nm, m_valid, 1'b1);
  endtask

  task automatic drain(input string nm, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || m_valid) && k < budget) begin step(); k++; end
    chk(nm, {exp_q.size(), m_valid}, 0);
  endtask

  // Monitor: every accepted word is popped from the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    logic hs;
    if (rst) begin
      stall_prev = 1'b0;
      hs_prev    = 1'b0;
    end else begin
      hs = m_valid && m_ready && !clr;
      if (fifo_rd_req) begin
        rd_cnt++;
        chk("rd_while_empty", fifo_empty, 1'b0);
        if (m_valid) chk("rd_only_on_lane2_hs", {m_lane, m_ready}, {2'd2, 1'b1});
      end
      if (clr) chk("rd_during_clr", fifo_rd_req, 1'b0);
      if (stall_prev) chk("stall_hold", {m_valid, m_lane, m_data}, {1'b1, prev_l, prev_d});
      if (hs) begin
        if (exp_q.size() == 0) chk("spurious_word", m_valid, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk("word", {m_lane, m_data}, {e.l, e.d});
          chk("frame_last", m_frame_last, (e.l == 2'd2) && (ent_done % FL == FL - 1));
          if (e.l == 2'd2) ent_done++;
        end
        if (m_frame_last && word_idx < 32) last_mask |= 32'd1 << word_idx;
        word_idx++;
        run = hs_prev ? run + 1 : 1;
        if (run > max_run) max_run = run;
      end
      hs_prev    = hs;
      stall_prev = m_valid && !m_ready && !clr;
      prev_d     = m_data;
      prev_l     = m_lane;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    rst = 1'b1; en = 1'b0; clr = 1'b0; m_ready = 1'b0;
    repeat (2) step();
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_data", m_data, 0);
    chk("rst_lane", m_lane, 0);
    chk("rst_last", m_frame_last, 1'b0);
    chk("rst_rd_req", fifo_rd_req, 1'b0);
    rst = 1'b0; en = 1'b1;
    step();

    // single entry
    max_run = 0; r0 = rd_cnt; m_ready = 1'b1;
    push({32'h3, 32'h2, 32'h1});
    drain("t1_drain", 50);
    chk("t1_rd_pulses", rd_cnt - r0, 1);
    chk("t1_run", max_run, 3);

    // back-to-back entries
    max_run = 0; r0 = rd_cnt;
    repeat (4) push_rand();
    drain("t2_drain", 50);
    chk("t2_run", max_run, 12);
    chk("t2_rd_pulses", rd_cnt - r0, 4);

    // stall on lane 1 with a second entry waiting in the FIFO
    m_ready = 1'b0; r0 = rd_cnt;
    push_rand(); push_rand();
    wait_valid("t3_valid");
    m_ready = 1'b1; step();
    m_ready = 1'b0; step(); step();
    chk("t3_lane_stall", {m_valid, m_lane}, {1'b1, 2'd1});
    chk("t3_no_early_rd", rd_cnt - r0, 1);
    m_ready = 1'b1;
    drain("t3_drain", 50);
    chk("t3_rd_pulses", rd_cnt - r0, 2);

    // frame markers: align the counter with a clear, then stream 4 entries
    clr = 1'b1; step(); clr = 1'b0;
    ent_done = 0; word_idx = 0; last_mask = '0;
    repeat (4) push_rand();
    drain("t4_drain", 50);
    chk("t4_last_mask", last_mask, (32'd1 << 5) | (32'd1 << 11));

    // clear in lane 1 after one full entry left the counter at 1
    push_rand();
    drain("t5_pre_drain", 50);
    m_ready = 1'b0;
    push_rand();
    wait_valid("t5_valid");
    m_ready = 1'b1; step();
    m_ready = 1'b1; clr = 1'b1;
    while (exp_q.size() != 0 && exp_q[0].l != 2'd0) void'(exp_q.pop_front());
    ent_done = 0;
    step();
    clr = 1'b0;
    chk("t5_valid_after_clr", m_valid, 1'b0);
    word_idx = 0; last_mask = '0;
    push_rand(); push_rand();
    drain("t5_drain", 50);
    chk("t5_last_mask", last_mask, 32'd1 << 5);

    // randomized traffic
    for (int c = 0; c < 200; c++) begin
      en      = ($urandom % 4) != 0;
      m_ready = ($urandom % 3) != 0;
      if (($urandom % 3) == 0 && (wp - rp) < 7'd60) push_rand();
      step();
    end
    en = 1'b1; m_ready = 1'b1;
    drain("rand_drain", 300);

    // async reset in the middle of an entry
    m_ready = 1'b0;
    push_rand();
    wait_valid("t6_valid");
    m_ready = 1'b1; step();
    m_ready = 1'b0; en = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("t6_valid", m_valid, 1'b0);
    chk("t6_data", m_data, 0);
    chk("t6_lane", m_lane, 0);
    chk("t6_last", m_frame_last, 1'b0);
    chk("t6_rd_req", fifo_rd_req, 1'b0);
    exp_q.delete(); ent_done = 0;
    step(); step();
    chk("t6_rd_req_hold", fifo_rd_req, 1'b0);
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
